// File: rtl/leaf_stream_buffer.sv
// -----------------------------------------------------------------------------
// leaf_stream_buffer
//
// Small synchronous valid/ready FIFO placed between a hierarchy node's producer
// and its consumer. It decouples the two sides, reports current occupancy and
// the high-water mark since reset, and can optionally count output transfers.
//
// Parameters
//   WIDTH : data width in bits (>= 1)
//   DEPTH : number of entries, power of two, >= 2
//   CW    : occupancy width, $clog2(DEPTH)+1 (derived; do not override)
//
// Ports
//   clk       in   1      single clock, all state updates on rising edge
//   rst       in   1      synchronous active-high reset
//   in_valid  in   1      producer has data
//   in_ready  out  1      buffer accepts data this cycle (count != DEPTH)
//   in_data   in   WIDTH  producer data
//   out_valid out  1      buffer holds data for consumer (count != 0)
//   out_ready in   1      consumer accepts data this cycle
//   out_data  out  WIDTH  head-of-queue data
//   count     out  CW     current occupancy, 0..DEPTH
//   hwm       out  CW     maximum occupancy reached since reset
//   xfer_cnt  out  16     saturating count of output transfers
//
// Optional feature macro: LEAF_STREAM_BUFFER_XFER_CNT_EN
//   defined   : xfer_cnt is a 16-bit register counting pops, saturating at
//               16'hFFFF, cleared by rst.
//   undefined : no counter logic; xfer_cnt is tied to 16'h0000.
//   The port list is the same in both builds.
// -----------------------------------------------------------------------------
module leaf_stream_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    hwm,
    output logic [15:0]      xfer_cnt
);

    localparam int PW = $clog2(DEPTH);

    // Storage and pointers. Pointers are exactly log2(DEPTH) bits so they
    // wrap modulo DEPTH without any explicit compare.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_hwm;

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count_nxt;

    // -------------------------------------------------------------------------
    // Handshake decode. Both flags come only from the registered count, so
    // there is no combinational path from out_ready to in_ready or from the
    // input side to the output side. A full buffer refuses a push even when
    // a pop happens in the same cycle.
    // -------------------------------------------------------------------------
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;

    assign w_push    = in_valid  && in_ready;
    assign w_pop     = out_valid && out_ready;

    // No bypass: head data always comes from storage, so a word pushed into
    // an empty buffer is visible one cycle later.
    assign out_data  = r_mem[r_rd_ptr];

    assign count     = r_count;
    assign hwm       = r_hwm;

    // -------------------------------------------------------------------------
    // Next occupancy: +1 on push only, -1 on pop only, otherwise unchanged.
    // -------------------------------------------------------------------------
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Storage write. Entries are cleared on reset so out_data reads zero
    // straight after reset regardless of prior contents.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, occupancy and high-water mark.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hwm    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= w_count_nxt;
            // High-water mark tracks the post-edge occupancy and never falls.
            if (w_count_nxt > r_hwm) begin
                r_hwm <= w_count_nxt;
            end
        end
    end

`ifdef LEAF_STREAM_BUFFER_XFER_CNT_EN
    // -------------------------------------------------------------------------
    // Output transfer counter, saturating so a long run never wraps to a
    // small value and hides activity.
    // -------------------------------------------------------------------------
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end
        return v + 16'd1;
    endfunction

    logic [15:0] r_xfer_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_cnt <= '0;
        end else if (w_pop) begin
            r_xfer_cnt <= sat_inc16(r_xfer_cnt);
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`else
    assign xfer_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_leaf_stream_buffer.sv
// -----------------------------------------------------------------------------
// tb_leaf_stream_buffer
//
// Directed bench for leaf_stream_buffer (WIDTH=8, DEPTH=4). Expected values are
// hand-computed constants; the only bench-side state is the number of pops
// since reset, used to predict xfer_cnt in either build of the counter macro.
// -----------------------------------------------------------------------------
module tb_leaf_stream_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
    logic [CW-1:0]    hwm;
    logic [15:0]      xfer_cnt;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    leaf_stream_buffer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count),
        .hwm      (hwm),
        .xfer_cnt (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_xfer();
`ifdef LEAF_STREAM_BUFFER_XFER_CNT_EN
        return (pops > 65535) ? 16'hFFFF : 16'(pops);
`else
        return 16'h0000;
`endif
    endfunction

    // Drive inputs, advance one edge, sample 1 ns later.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] vec [10];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset then idle
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_hwm",       32'(hwm),       32'd0);
        chk("rst_out_data",  32'(out_data),  32'h00);
        chk("rst_xfer",      32'(xfer_cnt),  32'(exp_xfer()));

        // Fill with out_ready=0
        step(1'b1, 8'h11, 1'b0);
        chk("fill1_count",     32'(count),     32'd1);
        chk("fill1_out_valid", 32'(out_valid), 32'd1);
        chk("fill1_out_data",  32'(out_data),  32'h11);
        step(1'b1, 8'h22, 1'b0);
        chk("fill2_count", 32'(count), 32'd2);
        step(1'b1, 8'h33, 1'b0);
        chk("fill3_count", 32'(count), 32'd3);
        step(1'b1, 8'h44, 1'b0);
        chk("fill4_count",    32'(count),    32'd4);
        chk("fill4_in_ready", 32'(in_ready), 32'd0);
        chk("fill4_hwm",      32'(hwm),      32'd4);

        // Stall while full: 0x55 must not be captured
        step(1'b1, 8'h55, 1'b0);
        chk("stall_count",    32'(count),    32'd4);
        chk("stall_out_data", 32'(out_data), 32'h11);

        // Drain in order
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("drain0_data", 32'(out_data), 32'h11);
        step(1'b0, 8'h00, 1'b1); pops++;
        chk("drain1_count", 32'(count), 32'd3);
        chk("drain1_data",  32'(out_data), 32'h22);
        step(1'b0, 8'h00, 1'b1); pops++;
        chk("drain2_data",  32'(out_data), 32'h33);
        step(1'b0, 8'h00, 1'b1); pops++;
        chk("drain3_data",  32'(out_data), 32'h44);
        step(1'b0, 8'h00, 1'b1); pops++;
        chk("drain_count",     32'(count),     32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_hwm",       32'(hwm),       32'd4);
        chk("drain_xfer",      32'(xfer_cnt),  32'(exp_xfer()));

        // Simultaneous push/pop at count=2
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hA2, 1'b0);
        chk("sim_pre_count", 32'(count), 32'd2);
        step(1'b1, 8'hA3, 1'b1); pops++;
        chk("sim1_count", 32'(count),    32'd2);
        chk("sim1_data",  32'(out_data), 32'hA2);
        step(1'b1, 8'hA4, 1'b1); pops++;
        chk("sim2_count", 32'(count),    32'd2);
        chk("sim2_data",  32'(out_data), 32'hA3);
        step(1'b1, 8'hA5, 1'b0);
        step(1'b1, 8'hA6, 1'b0);
        chk("full_again_count", 32'(count), 32'd4);

        // Full with in_valid and out_ready: pop only
        in_valid = 1'b1;
        in_data  = 8'hB0;
        out_ready = 1'b1;
        #1;
        chk("full_both_in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 8'hB0, 1'b1); pops++;
        chk("full_both_count",    32'(count),    32'd3);
        chk("full_both_in_ready2", 32'(in_ready), 32'd1);
        chk("full_both_data",     32'(out_data), 32'hA4);
        step(1'b1, 8'hB0, 1'b0);
        chk("held_accept_count", 32'(count), 32'd4);
        step(1'b0, 8'h00, 1'b1); pops++;
        chk("d_a5", 32'(out_data), 32'hA5);
        step(1'b0, 8'h00, 1'b1); pops++;
        chk("d_a6", 32'(out_data), 32'hA6);
        step(1'b0, 8'h00, 1'b1); pops++;
        chk("d_b0", 32'(out_data), 32'hB0);
        step(1'b0, 8'h00, 1'b1); pops++;
        chk("d_empty_count", 32'(count), 32'd0);
        chk("d_hwm",         32'(hwm),   32'd4);

        // Wrap-around: 10 words streamed continuously
        for (int k = 0; k < 10; k++) vec[k] = 8'(8'hC0 + k * 7);
        step(1'b1, vec[0], 1'b1);
        chk("wrap_first_count", 32'(count),    32'd1);
        chk("wrap_first_data",  32'(out_data), 32'(vec[0]));
        for (int k = 1; k < 10; k++) begin
            chk($sformatf("wrap_head%0d", k - 1), 32'(out_data), 32'(vec[k - 1]));
            step(1'b1, vec[k], 1'b1); pops++;
            chk($sformatf("wrap_count%0d", k), 32'(count), 32'd1);
        end
        chk("wrap_head9", 32'(out_data), 32'(vec[9]));
        step(1'b0, 8'h00, 1'b1); pops++;
        chk("wrap_end_count", 32'(count),   32'd0);
        chk("wrap_hwm",       32'(hwm),     32'd4);
        chk("wrap_xfer",      32'(xfer_cnt), 32'(exp_xfer()));

        // Reset mid-operation with push and pop asserted
        step(1'b1, 8'hD1, 1'b0);
        step(1'b1, 8'hD2, 1'b0);
        step(1'b1, 8'hD3, 1'b0);
        chk("mid_pre_count", 32'(count), 32'd3);
        rst = 1'b1;
        step(1'b1, 8'hEE, 1'b1);
        rst = 1'b0;
        pops = 0;
        chk("mid_count",     32'(count),     32'd0);
        chk("mid_hwm",       32'(hwm),       32'd0);
        chk("mid_in_ready",  32'(in_ready),  32'd1);
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_out_data",  32'(out_data),  32'h00);
        chk("mid_xfer",      32'(xfer_cnt),  32'(exp_xfer()));
        step(1'b1, 8'hF1, 1'b0);
        chk("post_count", 32'(count),    32'd1);
        chk("post_data",  32'(out_data), 32'hF1);
        chk("post_hwm",   32'(hwm),      32'd1);
        step(1'b0, 8'h00, 1'b1); pops++;
        chk("post_empty",     32'(count),     32'd0);
        chk("post_out_valid", 32'(out_valid), 32'd0);

`ifdef LEAF_STREAM_BUFFER_XFER_CNT_EN
        // Saturation: 70000 pops in total
        step(1'b1, 8'h5A, 1'b0);
        for (int k = 0; k < 70000; k++) begin
            step(1'b1, 8'h5A, 1'b1); pops++;
        end
        chk("xfer_sat", 32'(xfer_cnt), 32'h0000FFFF);
`else
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 8'(k), 1'b1);
            if (k > 0) pops++;
        end
        chk("xfer_off", 32'(xfer_cnt), 32'h00000000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
